nn_frame_resampler: RTL and testbench

Frame sequencer for the nearest-neighbour pitch-shift path. On `start` it latches the 32-bit shift ratio, sweeps the destination index 0..511 into `nn_multiplier`, and reads the source frame buffer at the returned `shifted_index`. It writes each fetched sample, or silence when the index is out of range, into the output frame buffer. It sits between the input frame BRAM and the output frame BRAM, with `nn_multiplier` as its combinational address-mapping helper.

---
 rtl/nn_frame_resampler.sv | 91 +++++++++
 tb/tb_nn_frame_resampler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/nn_frame_resampler.sv
// nn_frame_resampler: sweeps destination indices through nn_multiplier and copies source samples to the output frame.
// Optional macro NN_RESAMPLER_CLAMP_EN clamps out-of-range indices to the last source sample instead of writing silence.
module nn_frame_resampler #(
    parameter int FRAME_AW = 9,
    parameter int SAMPLE_W = 16,
    parameter int SHIFT_W  = 32,
    parameter int SIDX_W   = 11
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [SHIFT_W-1:0]  shift,
    output logic                busy,
    output logic                done,
    output logic [SHIFT_W-1:0]  mult_shift,
    output logic [FRAME_AW-1:0] mult_index,
    input  logic [SIDX_W-1:0]   mult_shifted,
    output logic                rd_en,
    output logic [FRAME_AW-1:0] rd_addr,
    input  logic [SAMPLE_W-1:0] rd_data,
    output logic                wr_en,
    output logic [FRAME_AW-1:0] wr_addr,
    output logic [SAMPLE_W-1:0] wr_data
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [FRAME_AW-1:0] LAST = '1;

    state_t              state_q, state_d;
    logic [FRAME_AW-1:0] idx_q, idx_d, dst_q;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic                valid_q, range_q, range_d, run, in_range;

    assign run      = state_q == RUN;
    assign in_range = ~|mult_shifted[SIDX_W-1:FRAME_AW];

`ifdef NN_RESAMPLER_CLAMP_EN
    assign rd_en   = run;
    assign rd_addr = !run ? '0 : in_range ? mult_shifted[FRAME_AW-1:0] : LAST;
    assign range_d = run;
`else
    assign rd_en   = run & in_range;
    assign rd_addr = run ? mult_shifted[FRAME_AW-1:0] : '0;
    assign range_d = rd_en;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                idx_d   = '0;
                shift_d = shift;
            end
            RUN: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) state_d = DRAIN;
            end
            DRAIN: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // One-stage pipeline aligns the write with the 1-cycle BRAM read latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            range_q <= 1'b0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            valid_q <= run;
            range_q <= range_d;
            dst_q   <= run ? idx_q : '0;
        end
    end

    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign mult_shift = shift_q;
    assign mult_index = idx_q;
    assign wr_en      = valid_q;
    assign wr_addr    = dst_q;
    assign wr_data    = range_q ? rd_data : '0;
endmodule

// File: tb/tb_nn_frame_resampler.sv
// tb_nn_frame_resampler: scoreboard bench with a source BRAM and nn_multiplier model around the resampler.
module tb_nn_frame_resampler;
`ifdef NN_RESAMPLER_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    typedef struct packed {logic [8:0] a; logic [15:0] d;} wr_t;

    logic        clock = 0, reset_n = 1, start = 0;
    logic [31:0] shift = 0, mult_shift;
    logic        busy, done, rd_en, wr_en;
    logic [8:0]  mult_index, rd_addr, wr_addr;
    logic [10:0] mult_shifted;
    logic [15:0] rd_data = 0, wr_data;
    logic [15:0] src [512];
    wr_t         q[$];
    int          checks = 0, errs = 0;

    always #5 clock = ~clock;

    nn_frame_resampler dut (
        .clock(clock), .reset_n(reset_n), .start(start), .shift(shift),
        .busy(busy), .done(done), .mult_shift(mult_shift), .mult_index(mult_index),
        .mult_shifted(mult_shifted), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    // nn_multiplier: index * ratio in 12.20 fixed point, saturated to 11 bits.
    function automatic logic [10:0] mul(input logic [8:0] i, input logic [31:0] s);
        logic [63:0] p;
        p = (64'(i) * 64'(s)) >> 20;
        return (p > 64'd2047) ? 11'd2047 : p[10:0];
    endfunction

    assign mult_shifted = mul(mult_index, mult_shift);

    always @(posedge clock) if (rd_en) rd_data <= src[rd_addr];

    always @(negedge clock) begin : monitor
        wr_t e;
        if (reset_n && wr_en) begin
            checks++;
            if (q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_write addr=%0d data=%h", wr_addr, wr_data);
            end else begin
                e = q.pop_front();
                if (wr_addr !== e.a || wr_data !== e.d) begin
                    errs++;
                    $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h", wr_addr, wr_data, e.a, e.d);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic expect_frame(input logic [31:0] sh, output int erd);
        wr_t e;
        logic [10:0] s;
        erd = 0;
        for (int n = 0; n < 512; n++) begin
            s = mul(9'(n), sh);
            if (s < 11'd512 || CLAMP) erd++;
            e.a = 9'(n);
            e.d = (s < 11'd512) ? src[s[8:0]] : (CLAMP ? src[511] : 16'h0);
            q.push_back(e);
        end
    endtask

    task automatic fill_random();
        for (int n = 0; n < 512; n++) src[n] = 16'($urandom);
    endtask

    task automatic check_reset_outputs();
        check("reset_ctl", {busy, done, rd_en, wr_en}, 0);
        check("reset_addr", {mult_index, rd_addr, wr_addr, wr_data}, 0);
        check("reset_shift", mult_shift, 0);
    endtask

    task automatic run(input logic [31:0] sh, input int pert, input int abrt);
        int dk = 0, nd = 0, nrd = 0, erd;
        expect_frame(sh, erd);
        @(negedge clock); start = 1; shift = sh;
        @(negedge clock); start = 0; shift = $urandom;
        for (int k = 1; k <= 520; k++) begin
            if (k == pert) begin start = 1; shift = 32'h300000; end
            if (k == pert + 1) start = 0;
            if (done) begin nd++; dk = k; end
            if (k <= 512 && rd_en) nrd++;
            if (k == 1 || k == 514 || k == 515) check("busy", busy, k < 515);
            if (k == abrt) begin
                #2 reset_n = 0;
                #1 check_reset_outputs();
                check("abort_remaining", q.size(), 513 - abrt);
                q.delete();
                for (int j = 0; j < 3; j++) begin
                    @(negedge clock);
                    check("abort_quiet", {done, wr_en, busy}, 0);
                end
                reset_n = 1;
                return;
            end
            @(negedge clock);
        end
        check("done_count", nd, 1);
        check("done_cycle", dk, 514);
        check("rd_en_cycles", nrd, erd);
        check("queue_drained", q.size(), 0);
    endtask

    task automatic back_to_back(input logic [31:0] sh);
        int d1 = 0, d2 = 0, nd = 0, nlow = 0, erd;
        expect_frame(sh, erd);
        expect_frame(sh, erd);
        @(negedge clock); start = 1; shift = sh;
        for (int k = 1; k <= 1035; k++) begin
            @(negedge clock);
            if (done) begin
                nd++;
                if (nd == 1) d1 = k; else d2 = k;
            end
            if (k <= 1029 && !wr_en) nlow++;
            if (k == 1029) start = 0;
        end
        check("b2b_done_count", nd, 2);
        check("b2b_first_done", d1, 514);
        check("b2b_period", d2 - d1, 515);
        check("b2b_wr_gaps", nlow, 5);
        check("b2b_queue_drained", q.size(), 0);
    endtask

    initial begin
        #3 reset_n = 0;
        #2 check_reset_outputs();
        repeat (3) @(negedge clock);
        reset_n = 1;
        for (int n = 0; n < 512; n++) src[n] = 16'(n + 16'h100);
        run(32'h100000, -1, 0);
        fill_random();
        run(32'h200000, -1, 0);
        fill_random();
        run(32'h080000, -1, 0);
        fill_random();
        run(32'h100000, 100, 0);
        run(32'h100000, -1, 200);
        run(32'h100000, -1, 0);
        for (int i = 0; i < 2; i++) begin
            fill_random();
            run($urandom_range(32'h600000, 0), -1, 0);
        end
        run(32'hFFFFFFFF, -1, 0);
        fill_random();
        back_to_back(32'h0C0000);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end
endmodule
